// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width default, register index width, ALU opcodes.
package riscv_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3
    } alu_ctrl_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side handshake, forwarding sources and ALU-side handshake.
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic                  in_use_imm;
    logic [3:0]            in_alu_ctrl;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_reg_write;
    logic                  flush;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic [XLEN-1:0]       mem_result;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic [XLEN-1:0]       wb_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_a;
    logic [XLEN-1:0]       out_b;
    logic [3:0]            out_alu_ctrl;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_write;

    // master: decode/ALU environment; slave: the ID/EX stage itself
    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_ctrl, in_rd_addr, in_reg_write, flush,
               mem_reg_write, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_result, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd_addr, out_reg_write
    );

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_ctrl, in_rd_addr, in_reg_write, flush,
               mem_reg_write, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_result, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd_addr, out_reg_write
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux (EX/MEM over MEM/WB over register file). Bypass only when FORWARD_EN is defined.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]       mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_result,
    output logic [XLEN-1:0]       operand
);
`ifdef FORWARD_EN
    // x0 is hardwired zero and must never pick up a forwarded value
    always_comb begin
        operand = rf_data;
        if (rs_addr == '0)
            operand = '0;
        else if (mem_reg_write && (mem_rd_addr == rs_addr))
            operand = mem_result;
        else if (wb_reg_write && (wb_rd_addr == rs_addr))
            operand = wb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, mem_reg_write, mem_rd_addr, mem_result,
                          wb_reg_write, wb_rd_addr, wb_result};
    assign operand    = rf_data;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and optional operand forwarding
// (forwarding enabled by defining FORWARD_EN).
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    id_ex_stage_if.slave  bus
);
    logic [XLEN-1:0]       fwd_a;
    logic [XLEN-1:0]       fwd_b;
    logic                  capture;
    logic                  vld_p0;
    logic [XLEN-1:0]       a_p0;
    logic [XLEN-1:0]       b_p0;
    logic [3:0]            alu_ctrl_p0;
    logic [REG_ADDR_W-1:0] rd_addr_p0;
    logic                  reg_write_p0;

    fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .rs_addr       (bus.in_rs1_addr),
        .rf_data       (bus.in_rs1_data),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd_addr   (bus.mem_rd_addr),
        .mem_result    (bus.mem_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_result     (bus.wb_result),
        .operand       (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .rs_addr       (bus.in_rs2_addr),
        .rf_data       (bus.in_rs2_data),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd_addr   (bus.mem_rd_addr),
        .mem_result    (bus.mem_result),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_result     (bus.wb_result),
        .operand       (fwd_b)
    );

    assign bus.in_ready = !vld_p0 || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    // ID -> EX boundary; flush wins over both capture and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0       <= 1'b0;
            a_p0         <= '0;
            b_p0         <= '0;
            alu_ctrl_p0  <= 4'(ALU_ADD);
            rd_addr_p0   <= '0;
            reg_write_p0 <= 1'b0;
        end else begin
            if (bus.flush)
                vld_p0 <= 1'b0;
            else if (capture)
                vld_p0 <= 1'b1;
            else if (bus.out_ready)
                vld_p0 <= 1'b0;

            if (capture) begin
                a_p0         <= fwd_a;
                b_p0         <= bus.in_use_imm ? bus.in_imm : fwd_b;
                alu_ctrl_p0  <= bus.in_alu_ctrl;
                rd_addr_p0   <= bus.in_rd_addr;
                reg_write_p0 <= bus.in_reg_write;
            end
        end
    end

    assign bus.out_valid     = vld_p0;
    assign bus.out_a         = a_p0;
    assign bus.out_b         = b_p0;
    assign bus.out_alu_ctrl  = alu_ctrl_p0;
    assign bus.out_rd_addr   = rd_addr_p0;
    assign bus.out_reg_write = reg_write_p0;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have in_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 SHALL have in_rs1_addr, in_rs2_addr  input  5 each  source register indices.
REQ-007 SHALL have in_rs1_data, in_rs2_data  input  XLEN each  register-file read data.
REQ-008 SHALL have in_imm  input  XLEN  sign-extended immediate; in_use_imm  input  1  selects imm as operand B.
REQ-009 SHALL have in_alu_ctrl  input  4  ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR); in_rd_addr  input  5; in_reg_write  input  1.
REQ-010 SHALL have flush  input  1  kill the held and incoming instruction.
REQ-011 SHALL have mem_reg_write  input  1, mem_rd_addr  input  5, mem_result  input  XLEN  EX/MEM forwarding source.
REQ-012 SHALL have wb_reg_write  input  1, wb_rd_addr  input  5, wb_result  input  XLEN  MEM/WB forwarding source.
REQ-013 SHALL have out_valid  output  1; out_ready  input  1  ALU side accepts.
REQ-014 SHALL have out_a, out_b  output  XLEN; out_alu_ctrl  output  4; out_rd_addr  output  5; out_reg_write  output  1.

Function
REQ-015 SHALL be a single registered stage: in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL capture on rising clk when in_valid && in_ready && !flush; out_valid = 1 next cycle (latency 1).
REQ-017 SHALL clear out_valid when out_ready && out_valid and no new capture occurs the same edge.
REQ-018 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 SHALL, on flush, set out_valid = 0 next edge, overriding capture and hold; data registers may keep stale values.
REQ-020 SHALL resolve each source operand at capture time: MEM match first, then WB match, else register-file data.
REQ-021 SHALL define a match as src_reg_write && src_rd_addr == rsN_addr && rsN_addr != 0; x0 never forwards and always yields 0 from the register file value.
REQ-022 SHALL drive out_b = in_imm when in_use_imm, ignoring rs2 forwarding.
REQ-023 SHALL pass in_alu_ctrl through unmodified, including undefined codes 4-15.
REQ-024 SHALL NOT detect load-use hazards; the upstream stall logic owns that.

Reset
REQ-025 SHALL, while rst_n = 0, force out_valid = 0, out_a = out_b = 0, out_alu_ctrl = 0, out_rd_addr = 0, out_reg_write = 0, asynchronously.
REQ-026 SHALL drive in_ready = 1 the first cycle after reset release.

Configuration
REQ-027 SHALL, with FORWARD_EN defined, implement REQ-020/021 forwarding.
REQ-028 SHALL, without FORWARD_EN, use in_rs1_data/in_rs2_data directly; mem_* and wb_* ports remain present but unused.

Structure
REQ-029 SHALL import XLEN default, REG_ADDR_W = 5, and the alu_ctrl_e enum from shared package riscv_pkg.
REQ-030 SHALL implement forwarding in sub-module fwd_mux, instantiated once per source operand.

Verification
REQ-031 Basic: rs1_data=5, rs2_data=7, alu_ctrl=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_alu_ctrl=0.
REQ-032 Forward priority: rs1_addr=3, mem_rd_addr=3 result 0xAA, wb_rd_addr=3 result 0xBB, both write=1 -> out_a=0xAA; mem_reg_write=0 -> out_a=0xBB.
REQ-033 x0: rs1_addr=0, mem_rd_addr=0, mem_reg_write=1, mem_result=0xFF, rs1_data=0 -> out_a=0.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> new instruction captured next edge.
REQ-035 Flush: flush=1 together with in_valid=1 and held instruction -> out_valid=0 next cycle.
REQ-036 Reset mid-operation: rst_n low while out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
